instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Parametrised instruction fetch front-end between the PC/branch logic and the instruction bus.
//  Issues sequential fetches from a boot address using a req/gnt/rvalid bus handshake.
//  Buffers fetched words with their PCs in a FIFO_DEPTH-entry prefetch queue and
//  presents them to decode via a valid/ready handshake.
//  Supports redirects (branch/jump/trap): flushes the queue and discards in-flight responses.
// PARAMETERS
//  ADDR_WIDTH  32     width of PCs and bus address
//  DATA_WIDTH  32     width of instruction word / bus read data
//  BOOT_ADDR   0      first fetch address after reset (low 2 bits must be 0)
//  FIFO_DEPTH  2      prefetch queue entries (power of 2, >=1)
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  reset          in   1           synchronous, active-high reset
//  redirect_valid in   1           restart fetch at redirect_pc this cycle
//  redirect_pc    in   ADDR_WIDTH  new fetch PC; bits [1:0] ignored (forced 0)
//  instr_valid    out  1           queue head holds a valid instruction
//  instr_ready    in   1           decode accepts head this cycle
//  instr          out  DATA_WIDTH  head instruction word
//  instr_pc       out  ADDR_WIDTH  PC of head instruction
//  ibus_req       out  1           fetch request
//  ibus_addr      out  ADDR_WIDTH  fetch address, stable while ibus_req=1 and no gnt
//  ibus_gnt       in   1           bus accepted the request this cycle
//  ibus_rvalid    in   1           read data valid; never earlier than cycle after gnt
//  ibus_rdata     in   DATA_WIDTH  read data
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset values: ibus_req=0, ibus_addr=BOOT_ADDR, instr_valid=0, instr=0, instr_pc=0.
//    fetch_pc=BOOT_ADDR, queue empty, discard=0, state IDLE.
//  - Reset asserted mid-operation overrides everything, including redirect, gnt and rvalid.
//    Any outstanding response arriving afterwards is ignored.
//  - State machine (ibus_req = state==REQ):
//    IDLE: go REQ when space = (count + outstanding) < FIFO_DEPTH.
//          First eligible edge after reset deasserts -> REQ, so ibus_req=1 one cycle after reset falls.
//    REQ:  ibus_addr=fetch_pc. On gnt: fetch_pc += 4 (mod 2^ADDR_WIDTH wrap), outstanding=1, go WAIT.
//    WAIT: on rvalid: push {fetch address, rdata} unless discard; outstanding=0; clear discard.
//          Then go REQ if space, else IDLE.
//  - At most one request outstanding. No new req in the cycle rvalid returns; back-to-back spacing >= 1 cycle.
//  - Queue:
//    instr_valid = count!=0; instr/instr_pc are registered head entries.
//    Latency: rvalid -> instr_valid is 1 cycle (no bypass).
//    Pop when instr_valid & instr_ready. Push and pop may occur in the same cycle; count is unchanged.
//    Full queue: no request issued, so overflow is impossible.
//    instr_ready while empty has no effect.
//  - Redirect (priority over all except reset):
//    Queue flushed next cycle (instr_valid=0); a simultaneous pop is absorbed by the flush.
//    fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b0}.
//    In REQ without gnt: ibus_addr retargets next cycle (bus allows retarget before grant).
//    In REQ with gnt, or in WAIT without rvalid: discard=1; the pending response is dropped.
//    In WAIT with rvalid the same cycle: that response is dropped.
//    Then normal flow resumes from redirect target.
//  - PC of each entry is the address sent when granted, not post-increment value.
// TESTING
//  1 Reset then gnt=1 every cycle, rvalid 1 cycle after gnt, ready=1:
//    -> ibus_addr 0x0,0x4,0x8..., instr_pc follows, instr=rdata.
//  2 ready=0, FIFO_DEPTH=2: -> exactly 2 entries (pc 0x0,0x4), then ibus_req stays 0.
//    Raising ready pops 0x0 and a new req to 0x8 follows.
//  3 Redirect to 0x1003 while WAIT for 0x8: -> rvalid data dropped, queue empty.
//    Next ibus_addr=0x1000, next instr_pc=0x1000.
//  4 Redirect in REQ with gnt=0 held: -> ibus_addr changes to the target next cycle.
//    No stale entry is ever pushed.
//  5 fetch_pc=0xFFFFFFFC granted: -> next ibus_addr=0x0 (wrap), entry pc=0xFFFFFFFC.
//  6 Reset asserted in WAIT, rvalid arrives during/after reset:
//    -> no push, instr_valid=0, fetch restarts at BOOT_ADDR.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Sequential instruction fetcher with prefetch queue and redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  ibus_req,
  output logic [ADDR_WIDTH-1:0] ibus_addr,
  input  logic                  ibus_gnt,
  input  logic                  ibus_rvalid,
  input  logic [DATA_WIDTH-1:0] ibus_rdata
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_discard;
  logic [c_cnt_w-1:0]    r_count;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];

  logic                  w_gnt;
  logic                  w_resp;
  logic                  w_push;
  logic                  w_pop;
  logic [c_cnt_w:0]      w_used;
  logic                  w_space;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign instr_valid = (r_count != '0);
  assign instr       = r_mem_data[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
  assign ibus_req    = (r_state == S_REQ);
  assign ibus_addr   = r_fetch_pc;

  assign w_gnt  = (r_state == S_REQ) && ibus_gnt;
  assign w_resp = (r_state == S_WAIT) && ibus_rvalid;
  // A response arriving together with a redirect belongs to the old stream.
  assign w_push = w_resp && !r_discard && !redirect_valid;
  assign w_pop  = instr_valid && instr_ready;

  // The outstanding fetch reserves a queue slot so a full queue never overflows.
  assign w_used  = {1'b0, r_count} + (c_cnt_w + 1)'(r_state == S_WAIT);
  assign w_space = (w_used < (c_cnt_w + 1)'(FIFO_DEPTH));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_space) w_state_next = S_REQ;
      S_REQ:   if (ibus_gnt) w_state_next = S_WAIT;
      S_WAIT:  if (ibus_rvalid) w_state_next = w_space ? S_REQ : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= BOOT_ADDR;
      r_req_addr <= '0;
      r_discard  <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else begin
      r_state <= w_state_next;

      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (w_gnt)
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);

      if (w_gnt)
        r_req_addr <= r_fetch_pc;

      if (w_gnt)
        r_discard <= redirect_valid;
      else if (w_resp)
        r_discard <= 1'b0;
      else if ((r_state == S_WAIT) && redirect_valid)
        r_discard <= 1'b1;

      if (redirect_valid) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem_data[r_wr_ptr] <= ibus_rdata;
          r_mem_pc[r_wr_ptr]   <= r_req_addr;
          r_wr_ptr             <= ptr_inc(r_wr_ptr);
        end
        if (w_pop)
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Purpose  : Directed + randomized bench with a transaction-level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference model: what decode should see, what the bus should be asked for.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic        m_out;
  logic        m_drop;
  int          bus_delay;

  int n_pass = 0, n_fail = 0, n_total = 0, n_pops = 0;
  int p_gnt, p_rv, p_ready, p_redir, d_max;
  logic        f_redir, f_rv, seen;
  logic [31:0] f_redir_pc, watch_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = BOOT; m_addr = '0; m_out = 1'b0; m_drop = 1'b0; bus_delay = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", ibus_req, 1'b0);
    chk("rst_addr", ibus_addr, BOOT);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
  endtask

  task automatic check_outputs();
    chk("instr_valid", instr_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0].data);
      chk("instr_pc", instr_pc, m_q[0].pc);
    end
    if (ibus_req) begin
      chk("ibus_addr", ibus_addr, m_pc);
      chk("req_while_outstanding", m_out, 1'b0);
      chk("req_with_full_queue", m_q.size() < DEPTH, 1'b1);
    end
    if (instr_valid && instr_pc == watch_pc) seen = 1'b1;
  endtask

  task automatic drive();
    redirect_valid = f_redir || ($urandom_range(0, 99) < p_redir);
    if (f_redir) redirect_pc = f_redir_pc;
    else if ($urandom_range(0, 9) == 0) redirect_pc = 32'hFFFF_FFF4 + $urandom_range(0, 11);
    else redirect_pc = $urandom_range(0, 4095);
    f_redir     = 1'b0;
    instr_ready = ($urandom_range(0, 99) < p_ready);
    ibus_gnt    = ibus_req && ($urandom_range(0, 99) < p_gnt);
    if (f_rv) ibus_rvalid = 1'b1;
    else ibus_rvalid = m_out && (bus_delay == 0) && ($urandom_range(0, 99) < p_rv);
    if (m_out && bus_delay > 0) bus_delay--;
    ibus_rdata = $urandom();
  endtask

  // Apply the effect of this cycle's inputs, as of the coming rising edge.
  task automatic model_update();
    if (reset) begin
      model_reset();
      return;
    end
    if (instr_valid && instr_ready && !redirect_valid && m_q.size() > 0) begin
      void'(m_q.pop_front());
      n_pops++;
    end
    if (ibus_rvalid && m_out) begin
      if (!m_drop && !redirect_valid) m_q.push_back(ent_t'{m_addr, ibus_rdata});
      m_out = 1'b0; m_drop = 1'b0;
    end
    if (ibus_req && ibus_gnt) begin
      m_addr = m_pc; m_out = 1'b1; m_drop = 1'b0;
      m_pc = m_pc + 32'd4;
      bus_delay = $urandom_range(0, d_max);
    end
    if (redirect_valid) begin
      m_q.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      if (m_out) m_drop = 1'b1;
    end
  endtask

  task automatic step();
    check_outputs();
    drive();
    model_update();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int g, input int rv, input int rd, input int rr, input int d);
    p_gnt = g; p_rv = rv; p_ready = rd; p_redir = rr; d_max = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic found;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0;
    f_redir = 1'b0; f_rv = 1'b0; f_redir_pc = '0; watch_pc = 32'h1; seen = 1'b0;
    knobs(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    model_reset();
    chk_reset_vals();
    reset = 1'b0;
    step();
    chk("req_after_reset", ibus_req, 1'b1);
    chk("addr_after_reset", ibus_addr, BOOT);

    // Full-throughput streaming from boot.
    knobs(100, 100, 100, 0, 0);
    run(30);
    chk("stream_progress", n_pops >= 8, 1'b1);

    // Decode stalled: queue fills with 0x0, 0x4 and fetching stops.
    do_reset();
    knobs(100, 100, 0, 0, 0);
    run(12);
    chk("full_valid", instr_valid, 1'b1);
    chk("full_head_pc", instr_pc, 32'h0);
    chk("full_no_req", ibus_req, 1'b0);
    knobs(0, 100, 100, 0, 0);
    step();
    knobs(0, 100, 0, 0, 0);
    step();
    chk("refill_req", ibus_req, 1'b1);
    chk("refill_addr", ibus_addr, 32'h8);

    // Redirect while waiting on the 0x8 response.
    knobs(100, 0, 100, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && m_addr == 32'h8) found = 1'b1;
      else step();
    end
    chk("reach_wait_0x8", found, 1'b1);
    f_redir = 1'b1; f_redir_pc = 32'h1003;
    watch_pc = 32'h1000; seen = 1'b0;
    step();
    chk("redirect_flush", instr_valid, 1'b0);
    knobs(100, 100, 100, 0, 0);
    run(12);
    chk("redirect_target_seen", seen, 1'b1);

    // Redirect while a request waits for grant.
    knobs(0, 100, 100, 0, 0);
    run(4);
    chk("req_held", ibus_req, 1'b1);
    f_redir = 1'b1; f_redir_pc = 32'h2000;
    step();
    chk("retarget_addr", ibus_addr, 32'h2000);
    knobs(100, 100, 100, 0, 1);
    run(10);

    // Address wrap at the top of memory.
    f_redir = 1'b1; f_redir_pc = 32'hFFFF_FFFC;
    watch_pc = 32'hFFFF_FFFC; seen = 1'b0;
    run(12);
    chk("wrap_entry_seen", seen, 1'b1);

    // Reset while a response is outstanding; late response must be ignored.
    knobs(100, 0, 100, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out) found = 1'b1;
      else step();
    end
    chk("reach_wait_for_reset", found, 1'b1);
    reset = 1'b1; f_rv = 1'b1;
    step();
    chk_reset_vals();
    reset = 1'b0;
    step();
    f_rv = 1'b0;
    chk("post_reset_valid", instr_valid, 1'b0);
    chk("post_reset_req", ibus_req, 1'b1);
    chk("post_reset_addr", ibus_addr, BOOT);

    // Randomized traffic including redirects.
    n_pops = 0;
    watch_pc = 32'h1;
    for (int c = 0; c < 15; c++) begin
      knobs($urandom_range(30, 100), $urandom_range(30, 100),
            $urandom_range(20, 100), $urandom_range(0, 8), $urandom_range(0, 3));
      run(200);
    end
    chk("random_progress", n_pops > 200, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
